// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
//   rx_state_t : receiver FSM states
//   DATA_BITS  : payload bits per frame
//   div_round  : rounded integer divide, never below 1 (tick divider sizing)
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned div_round(input int unsigned num, input int unsigned den);
    int unsigned q;
    q = (num + den / 2) / den;
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous rx line.
//   clk, rst : clock, async active-high reset
//   rx       : raw serial input
//   rx_s     : synchronised level
//   rx_fall  : 1-clk strobe on a synchronised high->low transition
// The chain resets to 1 so a reset never looks like a start edge. The edge
// strobe is also held off until every stage (and the previous-level flop)
// holds a real line sample, so a line that is low at reset release is not
// mistaken for a start bit: the receiver waits until rx has been seen high.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain    <= '1;
      prev     <= 1'b1;
      vld_pipe <= '0;
    end else begin
      chain    <= {chain[STAGES-2:0], rx};
      prev     <= chain[STAGES-1];
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  assign rx_s    = chain[STAGES-1];
  assign rx_fall = vld_pipe[STAGES] & prev & ~rx_s;

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver, 8N1 by default.
// Build option: define UART_RX_PARITY_EN for an 11-bit frame with a parity
// bit (sense set by PARITY_ODD); otherwise rx_parity_err is tied 0.
//   clk, rst      : clock, async active-high reset
//   rx            : asynchronous serial input, idle high
//   rx_byte       : last good byte (LSB first on the line), held until next
//   rx_done       : 1-clk pulse, rx_byte newly updated
//   rx_busy       : validated start bit through stop-bit sampling
//   rx_frame_err  : 1-clk pulse, stop bit sampled low
//   rx_parity_err : 1-clk pulse, parity mismatch
// Downstream treats every rx_done as a real byte, so corrupt or false frames
// must only ever produce an error pulse or nothing.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || SYNC_STAGES < 2 || PARITY_ODD > 1) begin : g_param_chk
    $error("uart_rx_byte: illegal parameter set");
  end

  localparam int unsigned DIV = div_round(CLK_HZ, BAUD * OVERSAMPLE);
  localparam int          DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int          OW  = $clog2(OVERSAMPLE);
  // three samples straddle the bit centre; the decision is taken on the third
  localparam logic [OW-1:0] S0   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] S1   = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] S2   = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [OW-1:0] LAST = OW'(OVERSAMPLE - 1);

  logic                 rx_s, rx_fall;
  rx_state_t            state;
  logic [DW-1:0]        div_cnt;
  logic [OW-1:0]        os_cnt;
  logic [1:0]           samp;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick, mid, bit_val;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign tick    = (div_cnt == DW'(DIV - 1));
  assign mid     = tick && (os_cnt == S2);
  assign bit_val = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign rx_busy = (state == DATA) || (state == PARITY) || (state == STOP);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic par_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err       <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_parity_err <= 1'b0;
      if (state == PARITY && mid)
        par_err <= bit_val ^ (^shift) ^ PAR_ODD;
      // a low stop bit reports as framing error only
      if (state == STOP && mid && bit_val && par_err)
        rx_parity_err <= 1'b1;
    end
  end
`else
  localparam logic par_err = 1'b0;
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      os_cnt       <= '0;
      samp         <= 2'b11;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_byte      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;

      // phase of the bit timing is anchored to the start edge
      if (state == IDLE && rx_fall) begin
        div_cnt <= '0;
        os_cnt  <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          os_cnt <= (os_cnt == LAST) ? '0 : os_cnt + 1'b1;
          if (os_cnt == S0) samp[0] <= rx_s;
          if (os_cnt == S1) samp[1] <= rx_s;
        end
      end

      // every state acts at mid-bit; os_cnt keeps running across states
      case (state)
        IDLE:  if (rx_fall) state <= START;
        START: if (mid) begin
          bit_cnt <= '0;
          state   <= bit_val ? IDLE : DATA;
        end
        DATA:  if (mid) begin
          shift   <= {bit_val, shift[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (mid) state <= STOP;
`endif
        STOP:  if (mid) begin
          if (!bit_val) begin
            rx_frame_err <= 1'b1;
            state        <= BREAK;
          end else begin
            if (!par_err) begin
              rx_byte <= shift;
              rx_done <= 1'b1;
            end
            state <= IDLE;
          end
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 16 clk per bit.
module tb_uart_rx_byte;

  localparam int BIT_CLK = 16;
  localparam logic PODD  = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_done, rx_busy, rx_frame_err, rx_parity_err;

  int errors = 0;
  int checks = 0;

  // pulse observations, gathered on the falling edge
  logic [7:0] done_q[$];
  int fe_cnt = 0, pe_cnt = 0, busy_cnt = 0, multi_cnt = 0;

  uart_rx_byte #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .SYNC_STAGES(2), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_byte(rx_byte), .rx_done(rx_done),
    .rx_busy(rx_busy), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done) done_q.push_back(rx_byte);
      if (rx_frame_err) fe_cnt++;
      if (rx_parity_err) pe_cnt++;
      if (rx_busy) busy_cnt++;
      if ((32'(rx_done) + 32'(rx_frame_err) + 32'(rx_parity_err)) > 1) multi_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    @(posedge clk);
    done_q.delete();
    fe_cnt = 0; pe_cnt = 0; busy_cnt = 0;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // full frame; stop_len in clocks lets a low stop bit be stretched into a break
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_v, input int stop_len);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ PODD ^ par_flip);
`endif
    rx = stop_v;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // reference: compare received-byte list against the frames sent
  task automatic check_bytes(input string tag, input logic [7:0] exp_q[$]);
    check({tag, "_count"}, done_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < done_q.size(); i++)
      check(tag, done_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [7:0] last_good;

    repeat (3) @(negedge clk);
    check("rst_byte", rx_byte, 8'h00);
    check("rst_done", rx_done, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_ferr", rx_frame_err, 1'b0);
    check("rst_perr", rx_parity_err, 1'b0);
    rst = 1'b0;
    idle(20);

    // single good byte
    clear_stats();
    send_frame(8'h10, 1'b0, 1'b1, BIT_CLK);
    idle(10);
    exp_q = '{8'h10};
    check_bytes("byte_10", exp_q);
    check("busy_len_10", (busy_cnt >= 140 && busy_cnt <= 148), 1'b1);
    check("ferr_10", fe_cnt, 0);
    check("perr_10", pe_cnt, 0);
    last_good = 8'h10;

    // short low glitch on idle line
    clear_stats();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check("glitch_done", done_q.size(), 0);
    check("glitch_ferr", fe_cnt, 0);
    check("glitch_busy", rx_busy, 1'b0);

    // bad stop bit held low as a break, then a good byte
    clear_stats();
    send_frame(8'h55, 1'b0, 1'b0, BIT_CLK + 40);
    idle(20);
    check("brk_ferr", fe_cnt, 1);
    check("brk_done", done_q.size(), 0);
    check("brk_byte_kept", rx_byte, last_good);
    clear_stats();
    send_frame(8'hA3, 1'b0, 1'b1, BIT_CLK);
    idle(10);
    exp_q = '{8'hA3};
    check_bytes("after_brk", exp_q);

    // directed back-to-back burst, zero idle
    clear_stats();
    exp_q = '{8'h69, 8'h5A, 8'h10, 8'hDE};
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b0, 1'b1, BIT_CLK);
    idle(10);
    check_bytes("b2b", exp_q);
    check("b2b_ferr", fe_cnt, 0);

    // random bytes with random idle gaps, including zero
    clear_stats();
    exp_q.delete();
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b0, 1'b1, BIT_CLK);
      idle($urandom_range(0, 20));
    end
    idle(10);
    check_bytes("rand", exp_q);
    check("rand_ferr", fe_cnt, 0);

    // reset after 4 data bits of 0xC3
    clear_stats();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'hC3 >> i));
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_byte", rx_byte, 8'h00);
    check("mid_rst_done", rx_done, 1'b0);
    check("mid_rst_busy", rx_busy, 1'b0);
    check("mid_rst_ferr", rx_frame_err, 1'b0);
    rst = 1'b0;
    idle(20);
    check("mid_rst_nopulse", done_q.size() + fe_cnt, 0);
    send_frame(8'hC3, 1'b0, 1'b1, BIT_CLK);
    idle(10);
    exp_q = '{8'hC3};
    check_bytes("after_rst", exp_q);

`ifdef UART_RX_PARITY_EN
    clear_stats();
    send_frame(8'h07, 1'b0, 1'b1, BIT_CLK);
    idle(10);
    exp_q = '{8'h07};
    check_bytes("par_good", exp_q);
    check("par_good_perr", pe_cnt, 0);
    clear_stats();
    send_frame(8'h07, 1'b1, 1'b1, BIT_CLK);
    idle(10);
    check("par_bad_perr", pe_cnt, 1);
    check("par_bad_done", done_q.size(), 0);
`endif

    check("pulse_exclusive", multi_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard stop well beyond the longest expected run
  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
